// File: rtl/vga_plot_arbiter_pkg.sv
// Shared screen geometry, field widths and arbiter state
// for the VGA plot arbiter.
package vga_plot_arbiter_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [X_W-1:0] SCREEN_X_MAX = 8'd159;
  localparam logic [Y_W-1:0] SCREEN_Y_MAX = 7'd119;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  function automatic logic in_screen(
    input logic [X_W-1:0] px,
    input logic [Y_W-1:0] py
  );
    return (px <= SCREEN_X_MAX) && (py <= SCREEN_Y_MAX);
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_clear_scanner.sv
// Raster counter for the clear sweep: x fastest, then y,
// wrapping to the origin after the last pixel.
module clear_scanner
  import vga_plot_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  output logic [X_W-1:0] sx,
  output logic [Y_W-1:0] sy,
  output logic           last
);

  assign last = (sx == SCREEN_X_MAX) && (sy == SCREEN_Y_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sx <= '0;
      sy <= '0;
    end else if (en) begin
      if (sx == SCREEN_X_MAX) begin
        sx <= '0;
        sy <= last ? '0 : sy + 1'b1;
      end else begin
        sx <= sx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter merging drawing-unit pixels and a
// full-screen clear sweep onto one vga_adapter port.
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int                   NUM_REQ   = 4,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR = 3'b000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [X_W*NUM_REQ-1:0]       req_x,
  input  logic [Y_W*NUM_REQ-1:0]       req_y,
  input  logic [COLOUR_W*NUM_REQ-1:0]  req_colour,
  input  logic                         clear_start,
  output logic                         clear_busy,
  output logic                         clear_done,
  output logic                         range_err,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state, state_nxt;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        cand;
  logic [PW-1:0]        gnt_idx;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic                 gnt_any;
  logic                 serve;
  logic                 xfer;
  logic                 sweep;
  logic                 pending;
  logic                 last;
  logic [X_W-1:0]       sx;
  logic [Y_W-1:0]       sy;

  logic [X_W-1:0]       rx [NUM_REQ];
  logic [Y_W-1:0]       ry [NUM_REQ];
  logic [COLOUR_W-1:0]  rc [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign rx[i] = req_x[i*X_W +: X_W];
    assign ry[i] = req_y[i*Y_W +: Y_W];
    assign rc[i] = req_colour[i*COLOUR_W +: COLOUR_W];
  end

  // search from ptr upward, wrapping modulo NUM_REQ
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  assign serve      = (state != CLEAR);
  assign req_ready  = serve ? gnt_oh : '0;
  assign xfer       = serve && gnt_any;
  assign sweep      = (state == CLEAR) && !clear_done;
  assign clear_busy = pending;

  clear_scanner u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (sweep),
    .sx      (sx),
    .sy      (sy),
    .last    (last)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (clear_start)     state_nxt = CLEAR;
        else if (|req_valid) state_nxt = SERVE;
      end
      SERVE: begin
        if (clear_start)     state_nxt = CLEAR;
        else if (!(|req_valid)) state_nxt = IDLE;
      end
      CLEAR: begin
        if (clear_done)      state_nxt = IDLE;
      end
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (xfer)
        ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // pending spans the whole sweep plus the clear_done cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= sweep && last;
      if (serve && clear_start)
        pending <= 1'b1;
      else if (!serve && clear_done)
        pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
      range_err <= 1'b0;
    end else begin
      plot <= 1'b0;
      if (sweep) begin
        x      <= sx;
        y      <= sy;
        colour <= BG_COLOUR;
        plot   <= 1'b1;
      end else if (xfer) begin
        if (in_screen(rx[gnt_idx], ry[gnt_idx])) begin
          x      <= rx[gnt_idx];
          y      <= ry[gnt_idx];
          colour <= rc[gnt_idx];
          plot   <= 1'b1;
        end else begin
          range_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: reference model compared every
// cycle plus directed scenarios with literal expectations.
module tb_vga_plot_arbiter;

  localparam int          N      = 4;
  localparam logic [2:0]  BG     = 3'b000;
  localparam int          PIXELS = 160 * 120;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_x;
  logic [7*N-1:0] req_y;
  logic [3*N-1:0] req_colour;
  logic           clear_start;
  logic           clear_busy;
  logic           clear_done;
  logic           range_err;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           plot;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_plot_arbiter #(.NUM_REQ(N), .BG_COLOUR(BG)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_colour  (req_colour),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .range_err   (range_err),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_ptr = 0;
  logic       m_clr = 1'b0;
  int         m_cnt = 0;
  logic       m_done = 1'b0;
  logic       m_rerr = 1'b0;
  logic [7:0] m_x = '0;
  logic [6:0] m_y = '0;
  logic [2:0] m_c = '0;
  logic       m_plot = 1'b0;
  int         m_g;
  logic [N-1:0] exp_ready;
  logic [7:0] g_x;
  logic [6:0] g_y;
  logic [2:0] g_c;

  function automatic int first_valid(input int start, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  always_comb begin
    m_g = first_valid(m_ptr, req_valid);
    exp_ready = '0;
    g_x = '0;
    g_y = '0;
    g_c = '0;
    if (m_g >= 0) begin
      g_x = req_x[8*m_g +: 8];
      g_y = req_y[7*m_g +: 7];
      g_c = req_colour[3*m_g +: 3];
      if (!m_clr) exp_ready[m_g] = 1'b1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr <= 0; m_clr <= 1'b0; m_cnt <= 0; m_done <= 1'b0;
      m_rerr <= 1'b0; m_x <= '0; m_y <= '0; m_c <= '0; m_plot <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_plot <= 1'b0;
      if (m_clr) begin
        if (m_cnt < PIXELS) begin
          m_x    <= 8'(m_cnt % 160);
          m_y    <= 7'(m_cnt / 160);
          m_c    <= BG;
          m_plot <= 1'b1;
          m_cnt  <= m_cnt + 1;
          m_done <= (m_cnt == PIXELS - 1);
        end else begin
          m_clr <= 1'b0;
        end
      end else begin
        if (m_g >= 0) begin
          if (g_x < 8'd160 && g_y < 7'd120) begin
            m_x <= g_x; m_y <= g_y; m_c <= g_c; m_plot <= 1'b1;
          end else begin
            m_rerr <= 1'b1;
          end
          m_ptr <= (m_g + 1) % N;
        end
        if (clear_start) begin
          m_clr <= 1'b1;
          m_cnt <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ready", 32'(req_ready), 32'(exp_ready));
    check("x", 32'(x), 32'(m_x));
    check("y", 32'(y), 32'(m_y));
    check("colour", 32'(colour), 32'(m_c));
    check("plot", 32'(plot), 32'(m_plot));
    check("clear_busy", 32'(clear_busy), 32'(m_clr));
    check("clear_done", 32'(clear_done), 32'(m_done));
    check("range_err", 32'(range_err), 32'(m_rerr));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] px,
                          input logic [6:0] py, input logic [2:0] pc);
    req_x[8*i +: 8]      = px;
    req_y[7*i +: 7]      = py;
    req_colour[3*i +: 3] = pc;
  endtask

  // clear run; repulse_at / reset_at select sweep-pixel events (-1 = none)
  task automatic run_clear(input int repulse_at, input int reset_at);
    int nplot, ndone, viol, lx, ly;
    bit fin, aborted;
    nplot = 0; ndone = 0; viol = 0; lx = 0; ly = 0;
    fin = 1'b0; aborted = 1'b0;
    set_lane(0, 8'd12, 7'd34, 3'b101);
    set_lane(3, 8'd56, 7'd78, 3'b110);
    req_valid   = 4'b1001;
    clear_start = 1'b1;
    #3;
    check("xfer_with_clear", 32'(req_ready != '0), 1);
    tick();
    clear_start = 1'b0;
    #3;
    check("pre_sweep_plot", 32'(plot), 1);
    check("pre_sweep_not_bg", 32'(colour != BG), 1);
    for (int c = 0; c < PIXELS + 100; c++) begin
      if (!clear_busy) begin
        fin = 1'b1;
        break;
      end
      if (req_ready != '0) viol++;
      if (plot && colour == BG) nplot++;
      if (clear_done) begin
        ndone++; lx = x; ly = y;
      end
      if (reset_at >= 0 && nplot == reset_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_colour", 32'(colour), 0);
        check("rst_plot", 32'(plot), 0);
        check("rst_busy", 32'(clear_busy), 0);
        aborted = 1'b1;
        break;
      end
      tick();
      clear_start = (nplot == repulse_at);
      #3;
    end
    clear_start = 1'b0;
    if (aborted) begin
      tick();
      tick();
      reset_n   = 1'b1;
      req_valid = 4'b1111;
      #3;
      check("after_rst_grant0", 32'(req_ready), 32'b0001);
      for (int c = 0; c < 20; c++) begin
        tick();
        #3;
        if (clear_done) ndone++;
      end
      check("after_rst_no_done", 32'(ndone), 0);
    end else begin
      check("clear_finished", 32'(fin), 1);
      check("clear_plots", 32'(nplot), 32'(PIXELS));
      check("clear_done_count", 32'(ndone), 1);
      check("clear_last_x", 32'(lx), 159);
      check("clear_last_y", 32'(ly), 119);
      check("clear_ready_blocked", 32'(viol), 0);
      check("grants_resume", 32'(req_ready != '0), 1);
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  initial begin
    logic [N-1:0] rr_exp [8];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
               4'b0001, 4'b0010, 4'b0100, 4'b1000};
    req_valid   = '0;
    req_x       = '0;
    req_y       = '0;
    req_colour  = '0;
    clear_start = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #3;
    check("reset_x", 32'(x), 0);
    check("reset_plot", 32'(plot), 0);
    check("reset_busy", 32'(clear_busy), 0);
    check("reset_rerr", 32'(range_err), 0);
    tick();

    // four requesters continuously valid
    for (int i = 0; i < N; i++)
      set_lane(i, 8'(10*i + 1), 7'(5*i + 2), 3'(i + 1));
    req_valid = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      #3;
      if (i < 8) check("rr_grant", 32'(req_ready), 32'(rr_exp[i]));
      if (i > 0) begin
        check("rr_plot", 32'(plot), 1);
        check("rr_x", 32'(x), 32'(10*((i-1) % 4) + 1));
      end
      tick();
      if (i == 7) req_valid = '0;
    end

    // single requester 2
    set_lane(2, 8'd79, 7'd63, 3'b100);
    req_valid = 4'b0100;
    #3 check("single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    #3;
    check("single_x", 32'(x), 79);
    check("single_y", 32'(y), 63);
    check("single_colour", 32'(colour), 32'b100);
    check("single_plot", 32'(plot), 1);
    tick();

    // x out of range
    set_lane(1, 8'd160, 7'd10, 3'b010);
    req_valid = 4'b0010;
    #3 check("oor_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    #3;
    check("oor_plot", 32'(plot), 0);
    check("oor_rerr", 32'(range_err), 1);
    check("oor_x_held", 32'(x), 79);
    repeat (3) tick();
    #3 check("rerr_sticky", 32'(range_err), 1);
    tick();

    // y out of range, then in-range corner
    set_lane(0, 8'd5, 7'd120, 3'b001);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    #3 check("oor_y_plot", 32'(plot), 0);
    tick();
    set_lane(0, 8'd159, 7'd119, 3'b111);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    #3;
    check("corner_plot", 32'(plot), 1);
    check("corner_x", 32'(x), 159);
    check("corner_y", 32'(y), 119);
    tick();

    run_clear(-1, -1);
    run_clear(5000, -1);
    run_clear(-1, 100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of drawing-unit requesters.
REQ-002 SHALL have parameter BG_COLOUR, default 3'b000, colour written by the clear sweep.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester pixel valid.
REQ-006 SHALL have port req_ready, output, NUM_REQ, per-requester pixel accepted (one-hot or zero).
REQ-007 SHALL have port req_x, input, 8*NUM_REQ, packed x coordinates; requester i in bits [8i+7:8i].
REQ-008 SHALL have port req_y, input, 7*NUM_REQ, packed y coordinates; requester i in bits [7i+6:7i].
REQ-009 SHALL have port req_colour, input, 3*NUM_REQ, packed colours; requester i in bits [3i+2:3i].
REQ-010 SHALL have port clear_start, input, 1, request full-screen clear.
REQ-011 SHALL have port clear_busy, output, 1, high while clear is pending or sweeping.
REQ-012 SHALL have port clear_done, output, 1, one-cycle pulse at sweep completion.
REQ-013 SHALL have port range_err, output, 1, sticky flag: an out-of-range pixel was dropped.
REQ-014 SHALL have ports x (8), y (7), colour (3), plot (1), outputs, driving the vga_adapter x/y/colour/plot inputs.

Function
REQ-015 SHALL use three states: IDLE, SERVE, CLEAR.
REQ-016 IDLE->SERVE when any req_valid is high and no clear is pending; SERVE->IDLE when no req_valid is high.
REQ-017 In IDLE/SERVE, with no clear pending, SHALL grant exactly one valid requester per cycle, round-robin, searching from (last granted index + 1) mod NUM_REQ; first grant after reset searches from index 0.
REQ-018 req_ready[i] SHALL be combinational from req_valid and the round-robin pointer; a transfer occurs on cycles where req_valid[i] and req_ready[i] are both high.
REQ-019 An accepted pixel SHALL appear on x/y/colour with plot=1 exactly one cycle after the transfer (registered outputs, latency 1).
REQ-020 Back-to-back transfers SHALL sustain one plot per cycle.
REQ-021 A pixel with x>159 or y>119 SHALL be accepted but produce plot=0, and SHALL set range_err.
REQ-022 On any cycle without a transfer or sweep pixel, plot SHALL be 0; x/y/colour hold their last values.
REQ-023 clear_start high in IDLE/SERVE SHALL set a pending flag; from the next cycle all req_ready SHALL be 0; the FSM enters CLEAR on that next cycle.
REQ-024 A transfer occurring in the same cycle as clear_start SHALL complete and be plotted before the first sweep pixel.
REQ-025 CLEAR SHALL emit 19200 pixels, one per cycle, colour BG_COLOUR, x counting 0..159 fastest, then y 0..119, plot=1 each, same latency as REQ-019.
REQ-026 clear_done SHALL pulse in the cycle the final pixel (159,119) is presented with plot=1; FSM returns to IDLE the next cycle.
REQ-027 clear_start during CLEAR SHALL be ignored (no restart, no second clear_done).
REQ-028 clear_busy SHALL be high from the cycle after clear_start through the clear_done cycle inclusive.
REQ-029 range_err SHALL clear only on reset.

Reset
REQ-030 On reset_n low, asynchronously: state IDLE, pointer 0, pending 0, sweep counters 0, x=0, y=0, colour=0, plot=0, clear_busy=0, clear_done=0, range_err=0.
REQ-031 Reset asserted mid-sweep or mid-transfer SHALL abandon the operation; no clear_done is emitted.

Structure
REQ-032 Shared package SHALL hold SCREEN_X_MAX=159, SCREEN_Y_MAX=119, X_W=8, Y_W=7, COLOUR_W=3, and the state enum.
REQ-033 The sweep counter SHALL be a sub-module clear_scanner (x/y raster counter with enable, last flag).

Verification
REQ-034 Single requester 2 valid with (79,63,3'b100) -> req_ready[2]=1 same cycle; next cycle x=79,y=63,colour=100,plot=1.
REQ-035 All 4 requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3, plot=1 on 8 consecutive cycles.
REQ-036 Requester 1 sends (160,10) -> req_ready[1]=1, plot stays 0, range_err=1 and stays 1.
REQ-037 clear_start pulse with requesters 0 and 3 valid -> no req_ready for 19200 cycles, 19200 plots, last at (159,119), clear_done pulse once, then grants resume.
REQ-038 clear_start re-pulsed at sweep pixel 5000 -> total still 19200 plots, one clear_done.
REQ-039 reset_n low at sweep pixel 100 -> outputs zero immediately; no clear_done; after release, requesters served from index 0.
